// File: rtl/led_pkg.sv
// Shared LED definitions: pattern modes, reset pattern and mode sequencing helpers.
// Macro LED_BREATHE_EN adds BREATHE to the mode rotation; without it BLINK wraps to ROTATE.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE  = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  // LEDs are active-low: 0 = lit
  localparam logic [5:0] LED_INIT    = 6'b111110;
  localparam logic [5:0] LED_ALL_ON  = 6'b000000;
  localparam logic [5:0] LED_ALL_OFF = 6'b111111;

  function automatic led_mode_e next_mode(input led_mode_e m);
    case (m)
      MODE_ROTATE: next_mode = MODE_BOUNCE;
      MODE_BOUNCE: next_mode = MODE_BLINK;
`ifdef LED_BREATHE_EN
      MODE_BLINK:  next_mode = MODE_BREATHE;
`endif
      default:     next_mode = MODE_ROTATE;
    endcase
  endfunction

  function automatic logic [5:0] init_pattern(input led_mode_e m);
    case (m)
      MODE_BLINK:   init_pattern = LED_ALL_ON;
      MODE_BREATHE: init_pattern = LED_ALL_OFF;
      default:      init_pattern = LED_INIT;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sched_if.sv
// Button path between the pattern scheduler and its debouncer.
// btn_n is the raw active-low button; level is the filtered level (1 = released);
// press pulses high for exactly one cycle on a filtered 1->0 edge, no handshake/backpressure.
interface led_pattern_sched_if;
  logic btn_n;
  logic level;
  logic press;

  modport master (input btn_n, output level, output press);
  modport slave  (output btn_n, input level, input press);
endinterface

// File: rtl/led_pattern_sched_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for an active-low button.
// The filtered level flips only after DB_CNT consecutive cycles of disagreement.
module btn_debounce #(
  parameter int DB_CNT = 2
) (
  input logic                 clk,
  input logic                 rst,
  led_pattern_sched_if.master bus
);

  localparam int             CW       = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronized level agrees with the filtered one restarts the count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;

endmodule

// File: rtl/led_pattern_sched.sv
// Six-LED pattern scheduler: a mode button cycles ROTATE/BOUNCE/BLINK(/BREATHE).
// Define LED_BREATHE_EN to build the BREATHE mode and its PWM/duty logic.
module led_pattern_sched
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int STEP_MS     = 500,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk_in,
  input  logic       btn_rst,
  input  logic       btn_mode,
  output logic [5:0] led,
  output logic [1:0] mode
);

  localparam int             STEP_CNT  = CLK_HZ / 1000 * STEP_MS;
  localparam int             DB_CNT    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int             SW        = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CNT - 1);

  led_mode_e     mode_q, mode_d;
  logic [5:0]    led_q, led_d;
  logic [SW-1:0] step_q, step_d;
  logic          dir_up_q, dir_up_d;
  logic          tick;
  logic          press;

  led_pattern_sched_if db_if ();
  assign db_if.btn_n = btn_mode;

  btn_debounce #(.DB_CNT(DB_CNT)) u_btn_debounce (
    .clk (clk_in),
    .rst (btn_rst),
    .bus (db_if.master)
  );

  assign press = db_if.press;
  assign tick  = (step_q == STEP_LAST);

`ifdef LED_BREATHE_EN
  localparam int            DUTY_CNT  = (STEP_CNT / 256 > 1) ? STEP_CNT / 256 : 1;
  localparam int            DW        = (DUTY_CNT > 1) ? $clog2(DUTY_CNT) : 1;
  localparam logic [DW-1:0] DUTY_LAST = DW'(DUTY_CNT - 1);

  logic [7:0]    pwm_q, pwm_d;
  logic [7:0]    duty_q, duty_d;
  logic          duty_up_q, duty_up_d;
  logic [DW-1:0] dstep_q, dstep_d;

  always_ff @(posedge clk_in or posedge btn_rst) begin
    if (btn_rst) begin
      pwm_q     <= '0;
      duty_q    <= '0;
      duty_up_q <= 1'b1;
      dstep_q   <= '0;
    end else begin
      pwm_q     <= pwm_d;
      duty_q    <= duty_d;
      duty_up_q <= duty_up_d;
      dstep_q   <= dstep_d;
    end
  end

  // Duty walks a 0->255->0 triangle, one step per DUTY_CNT cycles while breathing.
  always_comb begin
    pwm_d     = pwm_q + 8'd1;
    duty_d    = duty_q;
    duty_up_d = duty_up_q;
    dstep_d   = dstep_q;
    if (press) begin
      duty_d    = '0;
      duty_up_d = 1'b1;
      dstep_d   = '0;
    end else if (mode_q == MODE_BREATHE) begin
      if (dstep_q == DUTY_LAST) begin
        dstep_d = '0;
        if (duty_up_q) begin
          duty_d = duty_q + 8'd1;
          if (duty_q == 8'd254) duty_up_d = 1'b0;
        end else begin
          duty_d = duty_q - 8'd1;
          if (duty_q == 8'd1) duty_up_d = 1'b1;
        end
      end else begin
        dstep_d = dstep_q + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_in or posedge btn_rst) begin
    if (btn_rst) begin
      mode_q   <= MODE_ROTATE;
      led_q    <= LED_INIT;
      step_q   <= '0;
      dir_up_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
    end
  end

  // A press outranks a coincident tick: new pattern loads unshifted and the step restarts.
  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    dir_up_d = dir_up_q;
    step_d   = tick ? '0 : step_q + 1'b1;
    if (press) begin
      mode_d   = next_mode(mode_q);
      led_d    = init_pattern(next_mode(mode_q));
      dir_up_d = 1'b1;
      step_d   = '0;
    end else begin
      case (mode_q)
        MODE_ROTATE: if (tick) led_d = {led_q[4:0], led_q[5]};
        MODE_BOUNCE: begin
          if (tick) begin
            if (dir_up_q) begin
              led_d = {led_q[4:0], 1'b1};
              if (!led_q[4]) dir_up_d = 1'b0;
            end else begin
              led_d = {1'b1, led_q[5:1]};
              if (!led_q[1]) dir_up_d = 1'b1;
            end
          end
        end
        MODE_BLINK: if (tick) led_d = ~led_q;
`ifdef LED_BREATHE_EN
        MODE_BREATHE: led_d = (pwm_q < duty_q) ? LED_ALL_ON : LED_ALL_OFF;
`endif
        default: led_d = led_q;
      endcase
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
